// File: rtl/ffs16_seq.sv
// ffs16_seq: sequential find-first-set / find-first-clear on a 16-bit word.
//
// A scan is launched by a start pulse in IDLE. On that edge the operand is
// captured, inverted first when searching for a clear bit, and every
// following edge tests one bit in ascending order. The first set bit ends the
// scan with found=1 and idx=bit position. If bit 15 is also clear, the scan
// ends with found=0 and idx=0. A single-cycle done pulse marks completion.
//
// Ports
//   clk    in   1   system clock, rising edge
//   rst    in   1   asynchronous reset, active high
//   start  in   1   request pulse, sampled only in IDLE
//   A      in   16  operand, captured with an accepted start
//   mode   in   1   0 = lowest set bit, 1 = lowest clear bit
//   busy   out  1   high while in SCAN or DONE
//   done   out  1   one-cycle completion pulse
//   found  out  1   a matching bit exists in the captured operand
//   idx    out  4   index of the lowest matching bit (0 when found=0)
//
// Every output comes straight from a flop, so no input reaches an output
// within the same cycle.

module ffs16_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] A,
    input  logic        mode,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic [3:0]  idx
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] w_q, w_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic        found_q, found_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            w_q     <= 16'd0;
            cnt_q   <= 4'd0;
            idx_q   <= 4'd0;
            found_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            found_q <= found_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        found_d = found_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Searching for a clear bit is the same as searching the
                    // inverted word for a set bit.
                    w_d     = mode ? ~A : A;
                    cnt_d   = 4'd0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_q[cnt_q]) begin
                    idx_d   = cnt_q;
                    found_d = 1'b1;
                    state_d = S_DONE;
                end else if (cnt_q == 4'd15) begin
                    // Last bit tested without a match; the counter stops here
                    // rather than wrapping.
                    idx_d   = 4'd0;
                    found_d = 1'b0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status flags are registered from the next state so that they line up
    // with the state they describe without decoding logic on the outputs.
    always_comb begin
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign found = found_q;
    assign idx   = idx_q;

endmodule

// File: doc/ffs16_seq.md
FFS16_SEQ -- requirements
Module: ffs16_seq

Interface
REQ-001 The block SHALL have no parameters; datapath width is fixed at 16 bits.
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request pulse; SHALL be sampled only in IDLE.
REQ-005 A  input  16  operand word; SHALL be sampled on the same edge as an accepted start.
REQ-006 mode  input  1  search target, sampled with start: 0 = lowest set bit, 1 = lowest clear bit.
REQ-007 busy  output  1  high in SCAN and DONE.
REQ-008 done  output  1  one-cycle completion pulse.
REQ-009 found  output  1  1 = a matching bit exists in the latched operand.
REQ-010 idx  output  4  index of the lowest matching bit; SHALL be 0 when found=0.

Function
REQ-011 The block SHALL implement three states: IDLE, SCAN and DONE.
REQ-012 IDLE with start=1 SHALL move to SCAN on the edge.
- That same edge SHALL latch W = (mode ? ~A : A) and set the bit counter cnt to 0.
REQ-013 IDLE with start=0 SHALL remain in IDLE.
REQ-014 In SCAN, each edge SHALL examine W[cnt], one bit per cycle, in ascending order.
REQ-015 SCAN with W[cnt]=1 SHALL set idx=cnt and found=1, then go to DONE.
REQ-016 SCAN with W[cnt]=0 and cnt<15 SHALL increment cnt and remain in SCAN.
REQ-017 SCAN with W[cnt]=0 and cnt=15 SHALL set found=0 and idx=0, then go to DONE.
- The counter SHALL NOT wrap.
REQ-018 DONE SHALL assert done for exactly one cycle, then return to IDLE unconditionally.
REQ-019 Latency: if start is sampled at edge E0 and the lowest match is bit k, done SHALL be high in the cycle following edge E(k+1).
- With no match, done SHALL be high in the cycle following edge E16.
REQ-020 busy SHALL rise in the cycle after E0 and fall in the cycle after done.
REQ-021 start asserted while busy=1 (SCAN or DONE) SHALL be ignored.
- It SHALL NOT be queued and SHALL NOT alter W, cnt, idx or found.
REQ-022 Changes on A or mode after the accepting edge SHALL NOT affect the result in progress.
REQ-023 idx and found SHALL hold their values from the last completed scan until the next accepted start.
- They MAY be cleared when the next scan begins.
- Their values SHALL be valid whenever done=1.
REQ-024 start held high continuously SHALL launch a new scan on the first edge after the block returns to IDLE.
- The gap between scans SHALL be one IDLE cycle.
REQ-025 All outputs SHALL be driven from registers; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-026 rst=1 SHALL force IDLE, cnt=0 and W=0 immediately, without waiting for a clock edge.
- Outputs SHALL immediately read busy=0, done=0, found=0, idx=0.
REQ-027 Reset asserted mid-SCAN or in DONE SHALL abort the operation without producing a done pulse.
REQ-028 After rst deasserts, the first start SHALL be accepted on the first rising edge at which it is sampled high.

Verification
REQ-029 The bench SHALL cover the following directed scenarios:
- A=16'h0001, mode=0 -> done in the cycle after E1; found=1, idx=0.
- A=16'h8000, mode=0 -> done in the cycle after E16; found=1, idx=15.
- A=16'h0000, mode=0 -> done in the cycle after E16; found=0, idx=0.
- A=16'h00FF, mode=1 -> found=1, idx=8, done in the cycle after E9.
  - Then A=16'hFFFF, mode=1 -> found=0.
- A=16'h0400, mode=0; a second start with A=16'h0001 two cycles later; A changed mid-scan -> second start ignored.
  - Result SHALL be idx=10, found=1.
- Start with A=16'h8000; rst pulsed at cycle 5 asynchronously (between edges) -> outputs zero immediately and no done pulse.
  - A subsequent start with A=16'h0002 SHALL return idx=1.
